// File: rtl/pcs_sync_pkg.sv
// Shared types and constants for the 1000BASE-X receive synchronization block.
// Build option: SYNC_RD_CHECK_EN adds running-disparity consistency to the validity check.
package pcs_sync_pkg;

  typedef enum logic [3:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT_1,
    ACQUIRE_SYNC_1,
    COMMA_DETECT_2,
    ACQUIRE_SYNC_2,
    COMMA_DETECT_3,
    SYNC_ACQUIRED_1,
    SYNC_ACQUIRED_2,
    SYNC_ACQUIRED_2A,
    SYNC_ACQUIRED_3,
    SYNC_ACQUIRED_3A,
    SYNC_ACQUIRED_4,
    SYNC_ACQUIRED_4A
  } sync_state_t;

  localparam logic [6:0] COMMA_POS    = 7'b0011111;
  localparam logic [6:0] COMMA_NEG    = 7'b1100000;
  localparam logic [9:0] K28_5_RDN    = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP    = 10'b1100000101;
  localparam logic [1:0] GOOD_CGS_MAX = 2'd3;

  function automatic logic [3:0] ones_count(input logic [9:0] cg);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      n = n + {3'b000, cg[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cg_classifier.sv
// Combinational code-group classification: comma, validity, cgbad and next RD.
// Build option: SYNC_RD_CHECK_EN adds the rd/next_rd ports and the disparity rule.
module cg_classifier
  import pcs_sync_pkg::*;
(
  input  logic [9:0] code_group,
`ifdef SYNC_RD_CHECK_EN
  input  logic       rd,
  output logic       next_rd,
`endif
  input  logic       rx_even,
  output logic       comma,
  output logic       valid,
  output logic       cgbad
);

  logic [3:0] ones;

  always_comb begin
    ones  = ones_count(code_group);
    comma = (code_group[9:3] == COMMA_POS) || (code_group[9:3] == COMMA_NEG);
`ifdef SYNC_RD_CHECK_EN
    // rd = 1 means positive running disparity
    valid   = (ones == 4'd5) || ((ones == 4'd6) && !rd) || ((ones == 4'd4) && rd);
    next_rd = (ones == 4'd6) ? 1'b1 : ((ones == 4'd4) ? 1'b0 : rd);
`else
    valid   = (ones == 4'd4) || (ones == 4'd5) || (ones == 4'd6);
`endif
    cgbad = !valid || (comma && rx_even);
  end

endmodule

// File: rtl/pcs_synchronization.sv
// 1000BASE-X PCS receive code-group synchronization state machine.
// Build option: SYNC_RD_CHECK_EN enables running-disparity tracking in the validity check.
module pcs_synchronization
  import pcs_sync_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] rx_code_group,
  output logic       rx_even,
  output logic       sync_status,
  output logic [9:0] sudi
);

  sync_state_t state, state_nxt;
  logic [1:0]  good_cgs, good_cgs_nxt;
  logic        rx_even_nxt, sync_nxt;
  logic        comma, valid, cgbad;
`ifdef SYNC_RD_CHECK_EN
  logic        rd, rd_nxt;
`endif

  cg_classifier u_cg_classifier (
    .code_group (rx_code_group),
`ifdef SYNC_RD_CHECK_EN
    .rd         (rd),
    .next_rd    (rd_nxt),
`endif
    .rx_even    (rx_even),
    .comma      (comma),
    .valid      (valid),
    .cgbad      (cgbad)
  );

  always_comb begin
    state_nxt    = state;
    good_cgs_nxt = '0;
    case (state)
      LOSS_OF_SYNC:     if (comma) state_nxt = COMMA_DETECT_1;
      COMMA_DETECT_1:   state_nxt = (valid && !comma) ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1:   if (cgbad) state_nxt = LOSS_OF_SYNC;
                        else if (comma) state_nxt = COMMA_DETECT_2;
      COMMA_DETECT_2:   state_nxt = (valid && !comma) ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_2:   if (cgbad) state_nxt = LOSS_OF_SYNC;
                        else if (comma) state_nxt = COMMA_DETECT_3;
      COMMA_DETECT_3:   state_nxt = (valid && !comma) ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      SYNC_ACQUIRED_1:  if (cgbad) state_nxt = SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_2:  state_nxt = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
      SYNC_ACQUIRED_2A: if (cgbad) state_nxt = SYNC_ACQUIRED_3;
                        else if (good_cgs == GOOD_CGS_MAX) state_nxt = SYNC_ACQUIRED_1;
      SYNC_ACQUIRED_3:  state_nxt = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
      SYNC_ACQUIRED_3A: if (cgbad) state_nxt = SYNC_ACQUIRED_4;
                        else if (good_cgs == GOOD_CGS_MAX) state_nxt = SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_4:  state_nxt = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
      SYNC_ACQUIRED_4A: if (cgbad) state_nxt = LOSS_OF_SYNC;
                        else if (good_cgs == GOOD_CGS_MAX) state_nxt = SYNC_ACQUIRED_3;
      default:          state_nxt = LOSS_OF_SYNC;
    endcase

    // good_cgs counts good groups while parked in an nA state; cleared on every other path
    if (!cgbad) begin
      case (state)
        SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4:
          good_cgs_nxt = 2'd1;
        SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A:
          if (good_cgs != GOOD_CGS_MAX) good_cgs_nxt = good_cgs + 2'd1;
        default: good_cgs_nxt = '0;
      endcase
    end

    rx_even_nxt = !rx_even;
    if (state_nxt inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3}) rx_even_nxt = 1'b1;

    sync_nxt = state_nxt inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                                 SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
                                 SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOSS_OF_SYNC;
      good_cgs    <= '0;
      rx_even     <= 1'b0;
      sync_status <= 1'b0;
      sudi        <= '0;
`ifdef SYNC_RD_CHECK_EN
      rd          <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      good_cgs    <= good_cgs_nxt;
      rx_even     <= rx_even_nxt;
      sync_status <= sync_nxt;
      sudi        <= rx_code_group;
`ifdef SYNC_RD_CHECK_EN
      rd          <= rd_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pcs_synchronization.sv
// Scoreboard bench for pcs_synchronization: directed sync scenarios plus randomized streams.
// The reference model tracks sync as comma/bad-group counters, not as a state machine.
module tb_pcs_synchronization;
  import pcs_sync_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] rx_code_group = '0;
  logic       rx_even, sync_status;
  logic [9:0] sudi;

  always #5 clk = ~clk;

  pcs_synchronization dut (
    .clk           (clk),
    .reset         (reset),
    .rx_code_group (rx_code_group),
    .rx_even       (rx_even),
    .sync_status   (sync_status),
    .sudi          (sudi)
  );

  typedef struct packed {
    logic [9:0] sudi;
    logic       rx_even;
    logic       sync;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [9:0] D16_2  = 10'b1001000101;
  localparam logic [9:0] D21_5  = 10'b1010101010;
  localparam logic [9:0] BAD_CG = 10'b0000000000;

  logic [9:0] data_tbl [4] = '{10'b1001000101, 10'b0110110101, 10'b1010101010, 10'b0101010101};

  // Model: number of aligned commas accepted while acquiring, and outstanding bad marks once synced
  bit m_synced, m_expect_data, m_even, m_rd;
  int m_acq, m_bad_level, m_good_run;

  function automatic void model_reset();
    m_synced = 0; m_expect_data = 0; m_even = 0; m_rd = 0;
    m_acq = 0; m_bad_level = 0; m_good_run = 0;
  endfunction

  function automatic exp_t model_step(input logic [9:0] cg);
    int   ones;
    bit   comma, valid, bad, next_even;
    exp_t e;
    ones  = $countones(cg);
    comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    valid = (ones >= 4) && (ones <= 6);
`ifdef SYNC_RD_CHECK_EN
    if (ones == 6 && m_rd) valid = 0;
    if (ones == 4 && !m_rd) valid = 0;
    if (ones == 6) m_rd = 1;
    else if (ones == 4) m_rd = 0;
`endif
    bad       = !valid || (comma && m_even);
    next_even = !m_even;
    if (m_synced) begin
      if (bad) begin
        m_bad_level++;
        m_good_run = 0;
        if (m_bad_level == 4) begin
          m_synced = 0; m_acq = 0; m_bad_level = 0;
        end
      end else if (m_bad_level > 0) begin
        m_good_run++;
        if (m_good_run == 4) begin
          m_bad_level--;
          m_good_run = 0;
        end
      end
    end else if (m_expect_data) begin
      m_expect_data = 0;
      if (valid && !comma) begin
        if (m_acq == 3) begin
          m_synced = 1; m_bad_level = 0; m_good_run = 0;
        end
      end else begin
        m_acq = 0;
      end
    end else if (m_acq == 0) begin
      if (comma) begin
        m_acq = 1; m_expect_data = 1; next_even = 1;
      end
    end else begin
      if (bad) m_acq = 0;
      else if (comma) begin
        m_acq++; m_expect_data = 1; next_even = 1;
      end
    end
    m_even = next_even;
    e = {cg, m_even, m_synced};
    return e;
  endfunction

  function automatic void chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  task automatic drive(input logic [9:0] cg, input logic rst);
    exp_t z;
    @(negedge clk);
    reset         = rst;
    rx_code_group = cg;
    if (rst) begin
      model_reset();
      z = '0;
      sb_q.push_back(z);
    end else begin
      sb_q.push_back(model_step(cg));
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pairs(input int n);
    for (int i = 0; i < n; i++) begin
      drive(K28_5_RDN, 1'b0);
      drive(D16_2, 1'b0);
    end
  endtask

  // Monitor: one DUT output per clock, compared against the oldest queued expectation
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sudi", sudi, e.sudi);
        chk("rx_even", {9'd0, rx_even}, {9'd0, e.rx_even});
        chk("sync_status", {9'd0, sync_status}, {9'd0, e.sync});
      end
    end
  end

  initial begin
    int r;
    model_reset();

    // reset with arbitrary input
    drive(10'($urandom), 1'b1);
    drive(10'($urandom), 1'b1);
    after_edge();
    chk("reset_sync", {9'd0, sync_status}, 10'd0);
    chk("reset_sudi", sudi, 10'd0);

    // acquisition: sync rises on the edge of the data group after the third comma
    pairs(2);
    drive(K28_5_RDN, 1'b0);
    after_edge();
    chk("sync_before_3rd_data", {9'd0, sync_status}, 10'd0);
    chk("rx_even_on_comma", {9'd0, rx_even}, 10'd1);
    drive(D16_2, 1'b0);
    after_edge();
    chk("sync_after_3rd_data", {9'd0, sync_status}, 10'd1);
    pairs(3);

    // single invalid group then recovery
    drive(BAD_CG, 1'b0);
    after_edge();
    chk("sync_holds_one_bad", {9'd0, sync_status}, 10'd1);
    for (int i = 0; i < 5; i++) drive(D21_5, 1'b0);
    pairs(3);

    // four bad groups, each gap shorter than four good groups
    drive(BAD_CG, 1'b0); drive(D21_5, 1'b0); drive(D21_5, 1'b0);
    drive(BAD_CG, 1'b0); drive(D21_5, 1'b0);
    drive(BAD_CG, 1'b0); drive(D21_5, 1'b0); drive(D21_5, 1'b0); drive(D21_5, 1'b0);
    after_edge();
    chk("sync_before_4th_bad", {9'd0, sync_status}, 10'd1);
    drive(BAD_CG, 1'b0);
    after_edge();
    chk("sync_lost_4th_bad", {9'd0, sync_status}, 10'd0);

    // comma in the odd position while acquiring
    drive(K28_5_RDN, 1'b0); drive(D16_2, 1'b0); drive(D21_5, 1'b0);
    drive(K28_5_RDN, 1'b0);
    after_edge();
    chk("odd_comma_rx_even", {9'd0, rx_even}, 10'd0);
    pairs(2);
    after_edge();
    chk("odd_comma_no_sync", {9'd0, sync_status}, 10'd0);
    pairs(2);

    // reset mid-operation
    drive(D21_5, 1'b1);
    after_edge();
    chk("midreset_sync", {9'd0, sync_status}, 10'd0);
    chk("midreset_rx_even", {9'd0, rx_even}, 10'd0);

    // randomized: clean comma/data runs interleaved with noisy stretches
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 1) == 0) begin
        pairs(int'($urandom_range(2, 10)));
      end else begin
        for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
          r = int'($urandom_range(0, 99));
          if (r < 25) drive(($urandom_range(0, 1) != 0) ? K28_5_RDN : K28_5_RDP, 1'b0);
          else if (r < 80) drive(data_tbl[$urandom_range(0, 3)], 1'b0);
          else if (r < 98) drive(10'($urandom), 1'b0);
          else drive(10'($urandom), 1'b1);
        end
      end
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
